sata_oob_ctrl: RTL

// - Host-side SATA OOB link-initialisation sequencer, directly upstream of the OOB coder.
// - Issues COMRESET/COMWAKE commands to the coder and waits for the matching device responses.
// - Releases the transmitter (oobfinish) and switches from D10.2 to ALIGN, then signals link-up.

---
 rtl/sata_oob_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB link-initialisation sequencer feeding the OOB coder.
// Optional retry statistics counter enabled by defining SATA_OOB_CTRL_STAT_EN.
module sata_oob_ctrl #(
    parameter int unsigned CLKFREQ  = 100_000,
    parameter int unsigned RETRY_US = 10_000,
    parameter int unsigned ALIGN_US = 880,
    parameter int unsigned SYNC_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coder_ready,
    output logic       cominit,
    output logic       comwake,
    output logic       oobfinish,
    input  logic       rxcominit,
    input  logic       rxcomwake,
    input  logic       rxalign,
    input  logic       rxnonalign,
    output logic       txalign,
    output logic       linkup
`ifdef SATA_OOB_CTRL_STAT_EN
    ,
    output logic [7:0] retries
`endif
);

    localparam int unsigned TRETRY = (RETRY_US * CLKFREQ + 500) / 1000;
    localparam int unsigned TALIGN = (ALIGN_US * CLKFREQ + 500) / 1000;
    localparam int unsigned TW     = $clog2(TRETRY);
    localparam int unsigned SW     = $clog2(SYNC_CNT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_INIT,
        WAIT_INIT,
        SEND_WAKE,
        WAIT_WAKE,
        SEND_D102,
        SEND_ALIGN,
        LINKUP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   sync_cnt;
    logic [SW-1:0]   sync_cnt_nx;
    logic            tmo_retry;
    logic            tmo_align;

    assign tmo_retry = (timer == TW'(TRETRY - 1));
    assign tmo_align = (timer == TW'(TALIGN - 1));

    // State register, shared timer, sync counter and registered state decodes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            sync_cnt  <= '0;
            oobfinish <= 1'b0;
            txalign   <= 1'b0;
            linkup    <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= (state_nx != state) ? '0 : timer + TW'(1);
            sync_cnt  <= sync_cnt_nx;
            oobfinish <= (state_nx == SEND_D102) || (state_nx == SEND_ALIGN) ||
                         (state_nx == LINKUP);
            txalign   <= (state_nx == SEND_ALIGN);
            linkup    <= (state_nx == LINKUP);
        end
    end

    // Next state; rxcominit outranks every other event and any timeout
    always_comb begin
        state_nx    = state;
        sync_cnt_nx = sync_cnt;
        cominit     = 1'b0;
        comwake     = 1'b0;
        case (state)
            IDLE: state_nx = SEND_INIT;
            SEND_INIT: begin
                if (coder_ready) begin
                    cominit  = 1'b1;
                    state_nx = WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (rxcominit)      state_nx = SEND_WAKE;
                else if (tmo_retry) state_nx = SEND_INIT;
            end
            SEND_WAKE: begin
                if (coder_ready) begin
                    comwake  = 1'b1;
                    state_nx = WAIT_WAKE;
                end
            end
            WAIT_WAKE: begin
                if (rxcominit)      state_nx = SEND_WAKE;
                else if (rxcomwake) state_nx = SEND_D102;
                else if (tmo_retry) state_nx = SEND_INIT;
            end
            SEND_D102: begin
                if (rxcominit) begin
                    state_nx = SEND_WAKE;
                end else if (rxalign) begin
                    state_nx    = SEND_ALIGN;
                    sync_cnt_nx = '0;
                end else if (tmo_align) begin
                    state_nx = SEND_INIT;
                end
            end
            SEND_ALIGN: begin
                if (rxcominit) begin
                    state_nx = SEND_WAKE;
                end else if (rxalign) begin
                    sync_cnt_nx = '0;
                end else if (rxnonalign) begin
                    if (sync_cnt >= SW'(SYNC_CNT - 1)) begin
                        sync_cnt_nx = SW'(SYNC_CNT);
                        state_nx    = LINKUP;
                    end else begin
                        sync_cnt_nx = sync_cnt + SW'(1);
                    end
                end
            end
            LINKUP: begin
                if (rxcominit) state_nx = SEND_WAKE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef SATA_OOB_CTRL_STAT_EN
    // Every return to SEND_INIT from a waiting state is a timeout restart
    logic tmo_restart;
    assign tmo_restart = (state_nx == SEND_INIT) &&
                         ((state == WAIT_INIT) || (state == WAIT_WAKE) || (state == SEND_D102));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retries <= 8'd0;
        end else if ((state_nx == LINKUP) && (state != LINKUP)) begin
            retries <= 8'd0;
        end else if (tmo_restart && (retries != 8'hFF)) begin
            retries <= retries + 8'd1;
        end
    end
`endif

endmodule
